// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared widths, reset PC, fetch-state enum and HLT opcode for the SIMPLE core
package simple_pkg;

  localparam int DEF_PC_W = 16;
  localparam int DEF_INSTR_W = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  // Opcode field (top nibble) of the HLT instruction; the decoder raises halt_req on it.
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  function automatic logic is_hlt(input logic [DEF_INSTR_W-1:0] instr);
    return instr[DEF_INSTR_W-1 -: 4] == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, single-outstanding imem fetch, one-entry IR; optional FETCH_STATS_EN counter
module instr_fetch_unit
  import simple_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] COMMAND,
  output logic [PC_W-1:0]    cmd_pc,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               halted
`ifdef FETCH_STATS_EN
  , output logic [31:0]      fetch_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [PC_W-1:0] pc;
  logic drop;

  logic ack_v;
  logic take;
  logic slot_free;
  logic fill;
  logic issue;

  // An ack only counts while a request is outstanding, so a late ack after reset is ignored.
  assign ack_v     = imem_ack & imem_req;
  assign take      = cmd_valid & cmd_ready;
  assign slot_free = ~cmd_valid | cmd_ready;
  // A redirect in the ack cycle, or a pending drop, turns the returned word into wrong-path data.
  assign fill      = ack_v & ~drop & ~redirect;
  // New request only with nothing outstanding (a dropped ack retires its request this cycle)
  // and an IR slot that is free now, so the answer can never overwrite an unconsumed word.
  assign issue     = (state == FETCH) & ~redirect & ~halt_req & slot_free &
                     (~imem_req | (ack_v & drop));

  assign halted = (state == HALTED);

  // Fetch-state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next fetch state: redirect outranks halt_req; HALTING drains until nothing is outstanding or held.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (!redirect && halt_req) state_nxt = HALTING;
      HALTING: if (!imem_req && !cmd_valid) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  // Request tracking, wrong-path drop flag, instruction register and program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      COMMAND   <= '0;
      cmd_pc    <= '0;
      cmd_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= pc;
      end else if (ack_v) begin
        imem_req  <= 1'b0;
      end

      if (ack_v)                     drop <= 1'b0;
      else if (redirect && imem_req) drop <= 1'b1;

      if (redirect) begin
        cmd_valid <= 1'b0;
      end else if (fill) begin
        COMMAND   <= imem_rdata;
        cmd_pc    <= imem_addr;
        cmd_valid <= 1'b1;
      end else if (take) begin
        cmd_valid <= 1'b0;
      end

      if (redirect)  pc <= redirect_pc;
      else if (fill) pc <= imem_addr + PC_W'(1);
    end
  end

`ifdef FETCH_STATS_EN
  // Count delivered instructions; a same-cycle redirect cancels the handshake.
  always_ff @(posedge clk) begin
    if (rst)                   fetch_count <= '0;
    else if (take && !redirect) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed, table-driven check of instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_req2;
  logic [15:0] imem_addr, imem_addr2;
  logic        imem_ack, imem_ack2;
  logic [15:0] imem_rdata, imem_rdata2;
  logic [15:0] command, command2;
  logic [15:0] cmd_pc, cmd_pc2;
  logic        cmd_valid, cmd_valid2;
  logic        cmd_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        halted, halted2;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, fetch_count2;
`endif

  logic auto_mem;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .COMMAND(command), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count)
`endif
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_ff (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .COMMAND(command2), .cmd_pc(cmd_pc2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready),
    .redirect(1'b0), .redirect_pc(16'h0000), .halt_req(1'b0), .halted(halted2)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count2)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_cmd;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs [9];

  // Advance one clock; outputs are read 1 time unit after the edge. The memory models answer
  // in the same cycle the request is seen, with word = addr ^ 16'h5A00.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_ack   = imem_req;
      imem_rdata = imem_addr ^ 16'h5A00;
    end
    imem_ack2   = imem_req2;
    imem_rdata2 = imem_addr2 ^ 16'h5A00;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare the primary outputs; address only matters while requesting, COMMAND/cmd_pc while valid.
  task automatic expect_out(input string name, input logic e_req, input logic [15:0] e_addr,
                            input logic e_valid, input logic [15:0] e_cmd, input logic [15:0] e_pc,
                            input logic e_halted);
    logic [63:0] act, exp;
    act = {13'd0, imem_req, (e_req ? imem_addr : 16'h0), cmd_valid,
           (e_valid ? command : 16'h0), (e_valid ? cmd_pc : 16'h0), halted};
    exp = {13'd0, e_req, (e_req ? e_addr : 16'h0), e_valid,
           (e_valid ? e_cmd : 16'h0), (e_valid ? e_pc : 16'h0), e_halted};
    check(name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 16'h0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    halt_req = 1'b0;
    cmd_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    //            rdy   req   addr      valid cmd       pc
    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A00, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A01, 16'h0001};
    vecs[4] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A02, 16'h0002};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5A02, 16'h0002};
    vecs[7] = '{1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A03, 16'h0003};

    auto_mem = 1'b1;
    imem_ack2 = 1'b0;
    imem_rdata2 = 16'h0;
    do_reset();
    check("reset_outputs", {imem_req, imem_addr, command, cmd_pc, cmd_valid, halted},
          {1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});

    // Streaming fetch with one stall cycle; second instance starts at 16'hFFFF and wraps.
    for (int i = 0; i < 9; i++) begin
      cmd_ready = vecs[i].rdy;
      cyc();
      expect_out($sformatf("stream_%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_cmd, vecs[i].e_pc, 1'b0);
      if (i == 0) check("wrap_first_addr", {imem_req2, imem_addr2}, {1'b1, 16'hFFFF});
      if (i == 1) check("wrap_first_pc", {cmd_valid2, cmd_pc2, command2}, {1'b1, 16'hFFFF, 16'hA5FF});
      if (i == 2) check("wrap_second_addr", {imem_req2, imem_addr2}, {1'b1, 16'h0000});
      if (i == 3) check("wrap_second_pc", {cmd_valid2, cmd_pc2}, {1'b1, 16'h0000});
    end

    // Decoder stall: word held, no request until cmd_ready returns.
    auto_mem = 1'b0;
    do_reset();
    cmd_ready = 1'b0;
    cyc();
    expect_out("stall_req", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 16'hC160;
    cyc();
    expect_out("stall_fill", 1'b0, 16'h0, 1'b1, 16'hC160, 16'h0000, 1'b0);
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out($sformatf("stall_hold_%0d", i), 1'b0, 16'h0, 1'b1, 16'hC160, 16'h0000, 1'b0);
    end
    cmd_ready = 1'b1;
    cyc();
    expect_out("stall_resume", 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);

    // Redirect with the request to 0x0001 outstanding; its late answer is dropped.
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    expect_out("redir_hold_req", 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
    redirect = 1'b0;
    cyc();
    cyc();
    expect_out("redir_still_out", 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    cyc();
    expect_out("redir_drop_reissue", 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_rdata = 16'h1234;
    cyc();
    expect_out("redir_target_word", 1'b0, 16'h0, 1'b1, 16'h1234, 16'h0040, 1'b0);
    imem_ack = 1'b0;

    // Redirect in the same cycle as an ack.
    cyc();
    expect_out("same_cyc_issue", 1'b1, 16'h0041, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'h0080;
    cyc();
    expect_out("same_cyc_discard", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b0; redirect = 1'b0;
    cyc();
    expect_out("same_cyc_target_req", 1'b1, 16'h0080, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    cyc();
    expect_out("same_cyc_target_word", 1'b0, 16'h0, 1'b1, 16'h2222, 16'h0080, 1'b0);
    imem_ack = 1'b0;

    // Halt with one request outstanding: that word still arrives, then fetch stops.
    cyc();
    expect_out("halt_pre_req", 1'b1, 16'h0081, 1'b0, 16'h0, 16'h0, 1'b0);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    cmd_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h3333;
    cyc();
    expect_out("halt_drain_word", 1'b0, 16'h0, 1'b1, 16'h3333, 16'h0081, 1'b0);
    imem_ack = 1'b0;
    cyc();
    expect_out("halt_hold", 1'b0, 16'h0, 1'b1, 16'h3333, 16'h0081, 1'b0);
    cmd_ready = 1'b1;
    cyc();
    expect_out("halt_consumed", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc();
    expect_out("halted_set", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    expect_out("halted_stays", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);

    // Reset restarts fetching; an ack arriving right after reset is ignored.
    do_reset();
    cyc();
    expect_out("post_halt_reset", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h9999;
    cyc();
    expect_out("late_ack_ignored", 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
    imem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
